// File: rtl/cell_plotter_if.sv
// Request/response and VGA pixel bundle between the snake controller and the cell plotter.
// The controller side uses the master modport and the plotter uses the slave modport.
interface cell_plotter_if;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [1:0] status;
  logic       go;
  logic       clear;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output x_in, y_in, status, go, clear,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  x_in, y_in, status, go, clear,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/cell_plotter.sv
// Expands a cell draw request into CELL x CELL pixel writes, or raster-clears the screen.
// Every output is a register; a one-cycle tail after the last pixel keeps done aligned with FINISH.
module cell_plotter #(
  parameter int          CELL      = 4,
  parameter int          SCR_W     = 160,
  parameter int          SCR_H     = 120,
  parameter logic [2:0]  COL_BG    = 3'b000,
  parameter logic [2:0]  COL_SNAKE = 3'b010,
  parameter logic [2:0]  COL_FOOD  = 3'b100,
  parameter logic [2:0]  COL_WALL  = 3'b111
) (
  input  logic           clk,
  input  logic           reset,
  cell_plotter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BLOCK, CLEAR, FINISH} state_t;

  state_t     r_state, w_state;
  logic [7:0] r_x0, w_x0;
  logic [6:0] r_y0, w_y0;
  logic [2:0] r_col, w_col;
  logic [7:0] r_cx, w_cx;
  logic [6:0] r_cy, w_cy;
  logic       r_end, w_end;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_plot, w_plot;
  logic [7:0] r_vx, w_vx;
  logic [6:0] r_vy, w_vy;

  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic       w_in;

  function automatic logic [2:0] map_col(input logic [1:0] st);
    case (st)
      2'd0:    map_col = COL_BG;
      2'd1:    map_col = COL_SNAKE;
      2'd2:    map_col = COL_FOOD;
      default: map_col = COL_WALL;
    endcase
  endfunction

  // Wide sums so cells hanging off the right/bottom edge clip instead of wrapping.
  assign w_sx = {1'b0, r_x0} + {1'b0, r_cx};
  assign w_sy = {1'b0, r_y0} + {1'b0, r_cy};
  assign w_in = (w_sx < 9'(SCR_W)) && (w_sy < 8'(SCR_H));

  always_comb begin
    w_state = r_state;
    w_x0    = r_x0;
    w_y0    = r_y0;
    w_col   = r_col;
    w_cx    = r_cx;
    w_cy    = r_cy;
    w_end   = r_end;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_plot  = 1'b0;
    w_vx    = r_vx;
    w_vy    = r_vy;
    case (r_state)
      IDLE: begin
        if (bus.clear) begin
          w_col   = COL_BG;
          w_cx    = '0;
          w_cy    = '0;
          w_end   = 1'b0;
          w_busy  = 1'b1;
          w_state = CLEAR;
        end else if (bus.go) begin
          w_x0    = bus.x_in;
          w_y0    = bus.y_in;
          w_col   = map_col(bus.status);
          w_cx    = '0;
          w_cy    = '0;
          w_end   = 1'b0;
          w_busy  = 1'b1;
          w_state = BLOCK;
        end
      end
      BLOCK: begin
        if (r_end) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = FINISH;
        end else begin
          w_plot = w_in;
          if (w_in) begin
            w_vx = w_sx[7:0];
            w_vy = w_sy[6:0];
          end
          if (r_cx == 8'(CELL - 1)) begin
            w_cx = '0;
            if (r_cy == 7'(CELL - 1)) w_end = 1'b1;
            else                      w_cy  = r_cy + 7'd1;
          end else begin
            w_cx = r_cx + 8'd1;
          end
        end
      end
      CLEAR: begin
        if (r_end) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = FINISH;
        end else begin
          w_plot = 1'b1;
          w_vx   = r_cx;
          w_vy   = r_cy;
          if (r_cx == 8'(SCR_W - 1)) begin
            w_cx = '0;
            if (r_cy == 7'(SCR_H - 1)) w_end = 1'b1;
            else                       w_cy  = r_cy + 7'd1;
          end else begin
            w_cx = r_cx + 8'd1;
          end
        end
      end
      FINISH: begin
        w_end   = 1'b0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x0    <= '0;
      r_y0    <= '0;
      r_col   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_plot  <= 1'b0;
      r_vx    <= '0;
      r_vy    <= '0;
    end else begin
      r_state <= w_state;
      r_x0    <= w_x0;
      r_y0    <= w_y0;
      r_col   <= w_col;
      r_cx    <= w_cx;
      r_cy    <= w_cy;
      r_end   <= w_end;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_plot  <= w_plot;
      r_vx    <= w_vx;
      r_vy    <= w_vy;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.vga_x      = r_vx;
  assign bus.vga_y      = r_vy;
  assign bus.vga_colour = r_col;
  assign bus.vga_plot   = r_plot;

endmodule

// File: tb/tb_cell_plotter.sv
// Scoreboard bench for cell_plotter: stimulus pushes timestamped pixel/done events,
// a negedge monitor pops and compares whatever the plotter emits.
module tb_cell_plotter;

  typedef struct packed {
    logic        kind;   // 0 pixel, 1 done
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic [31:0] t;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  sb[$];

  cell_plotter_if bus();

  cell_plotter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input string name, input ev_t act);
    ev_t exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event %h, nothing expected (cycle %0d)", name, act, cyc);
    end else begin
      exp = sb.pop_front();
      chk(name, 64'(act), 64'(exp));
    end
  endtask

  // Monitor: compares each emitted pixel and done pulse against the queue head.
  always @(negedge clk) begin
    ev_t a;
    if (bus.vga_plot) begin
      a = '{kind: 1'b0, x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour, t: cyc};
      pop_chk("pixel", a);
      chk("busy_on_plot", 64'(bus.busy), 64'd1);
    end
    if (bus.done) begin
      a = '{kind: 1'b1, x: 8'd0, y: 7'd0, c: 3'd0, t: cyc};
      pop_chk("done", a);
      chk("busy_on_done", 64'(bus.busy), 64'd0);
    end
  end

  task automatic push_block(input int x0, input int y0, input logic [2:0] col, input int a);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        if (x0 + dx < 160 && y0 + dy < 120)
          sb.push_back('{1'b0, 8'(x0 + dx), 7'(y0 + dy), col, 32'(a + 1 + dy * 4 + dx)});
    sb.push_back('{1'b1, 8'd0, 7'd0, 3'd0, 32'(a + 17)});
  endtask

  task automatic push_clear(input int a);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        sb.push_back('{1'b0, 8'(x), 7'(y), 3'b000, 32'(a + 1 + y * 160 + x)});
    sb.push_back('{1'b1, 8'd0, 7'd0, 3'd0, 32'(a + 19201)});
  endtask

  // Drive a request for the next edge (DUT must be in IDLE there); a = acceptance edge count.
  task automatic accept(input int x, input int y, input int st, input logic clr, output int a);
    bus.x_in = 8'(x);
    bus.y_in = 7'(y);
    bus.status = 2'(st);
    bus.go = 1'b1;
    bus.clear = clr;
    @(posedge clk); #1;
    a = cyc;
    bus.go = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  // Leaves the bench one cycle after done, so the next request lands in IDLE.
  task automatic after_done(input int budget);
    wait_done(budget);
    @(posedge clk); #1;
  endtask

  initial begin
    int a;
    int b;
    bus.x_in = '0; bus.y_in = '0; bus.status = '0; bus.go = 1'b0; bus.clear = 1'b0;

    // Reset with a request pending: must not start anything
    bus.go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", 64'(bus.vga_plot), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_xy", 64'({bus.vga_x, bus.vga_y}), 64'd0);
    chk("rst_col", 64'(bus.vga_colour), 64'd0);
    bus.go = 1'b0;
    reset = 1'b0;

    // Plain snake cell
    accept(8, 4, 1, 1'b0, a);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    push_block(8, 4, 3'b010, a);
    after_done(40);

    // Corner cell, 4 of 16 pixels clipped in
    accept(158, 118, 2, 1'b0, a);
    push_block(158, 118, 3'b100, a);
    after_done(40);

    // Clear and go together: clear wins, go dropped
    accept(20, 20, 3, 1'b1, a);
    push_clear(a);
    after_done(20000);

    // Repeated go while busy: one block; go the cycle after done draws another
    accept(20, 40, 1, 1'b0, a);
    push_block(20, 40, 3'b010, a);
    for (int k = 1; k <= 16; k++) begin
      bus.x_in = 8'(100 + k);
      bus.status = 2'd3;
      bus.go = (k == 2 || k == 5 || k == 10 || k == 16);
      @(posedge clk); #1;
    end
    bus.go = 1'b0;
    after_done(40);
    accept(24, 40, 2, 1'b0, a);
    push_block(24, 40, 3'b100, a);
    after_done(40);

    // Reset during the 7th pixel aborts the block without done
    accept(40, 20, 2, 1'b0, a);
    for (int i = 0; i < 7; i++)
      sb.push_back('{1'b0, 8'(40 + (i % 4)), 7'(20 + (i / 4)), 3'b100, 32'(a + 1 + i)});
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_plot", 64'(bus.vga_plot), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    accept(60, 60, 3, 1'b0, a);
    push_block(60, 60, 3'b111, a);
    after_done(40);

    // Back-to-back with go held high: inputs change right after first acceptance
    bus.x_in = 8'd0; bus.y_in = 7'd0; bus.status = 2'd0; bus.go = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    bus.x_in = 8'd4;
    bus.status = 2'd3;
    b = a + 19;
    push_block(0, 0, 3'b000, a);
    push_block(4, 0, 3'b111, b);
    repeat (19) @(posedge clk);
    #1;
    bus.go = 1'b0;
    wait_done(40);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
